// File: rtl/ctrl_decode_pipe.sv
// Pipelined RV32I main-control decoder: registers the control bundle into ID/EX,
// stalls on load-use hazards, honours branch flush and sequences the ML coprocessor.
module ctrl_decode_pipe #(
   parameter logic [6:0] COP_OPCODE  = 7'b0001011,
   parameter int         COP_TIMEOUT = 1024,
   parameter bit         HAZARD_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic        flush_i,
   input  logic        cop_ready,
   input  logic        cop_done,
   output logic        id_stall,
   output logic        cop_req,
   output logic        cop_err,
   output logic        ex_valid,
   output logic [1:0]  ex_alu_op,
   output logic        ex_alu_src,
   output logic        ex_alu_a_pc,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_branch,
   output logic        ex_jump,
   output logic [1:0]  ex_wb_sel,
   output logic [4:0]  ex_rd,
   output logic        ex_illegal
);

   localparam int CNT_W = $clog2(COP_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COP_TIMEOUT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic       valid;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       alu_a_pc;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [1:0] wb_sel;
      logic [4:0] rd;
      logic       illegal;
   } ctrl_t;

   typedef enum logic [1:0] {S_RUN, S_COP_REQ, S_COP_BUSY} state_t;

   state_t           state_q;
   ctrl_t            ex_q, ex_d, dec;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       cop_rd_q;
   logic             cop_req_q, cop_err_q;
   logic             stall_d;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic       uses_rs2, hazard, cop_in_id, cop_start, timeout;
   logic       unused_instr;

   assign opcode       = id_instr[6:0];
   assign rd           = id_instr[11:7];
   assign rs1          = id_instr[19:15];
   assign rs2          = id_instr[24:20];
   assign unused_instr = ^{id_instr[31:25], id_instr[14:12]};

   // NOTE: every field gets a default before the case so no latch can be inferred.
   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.rd    = rd;
      case (opcode)
         OP_R:      begin dec.alu_op = 2'b10; dec.reg_write = 1'b1; end
         OP_IMM:    begin dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OP_LOAD:   begin
            dec.alu_src  = 1'b1; dec.mem_read  = 1'b1;
            dec.wb_sel   = 2'b01; dec.reg_write = 1'b1;
         end
         OP_STORE:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
         OP_BRANCH: begin dec.alu_op = 2'b01; dec.branch = 1'b1; end
         OP_JAL:    begin
            dec.alu_a_pc = 1'b1; dec.alu_src   = 1'b1; dec.jump = 1'b1;
            dec.wb_sel   = 2'b10; dec.reg_write = 1'b1;
         end
         OP_JALR:   begin
            dec.alu_src = 1'b1; dec.jump = 1'b1;
            dec.wb_sel  = 2'b10; dec.reg_write = 1'b1;
         end
         OP_LUI:    begin dec.alu_op = 2'b11; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OP_AUIPC:  begin dec.alu_a_pc = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         default:   dec.illegal = 1'b1;
      endcase
      if (rd == 5'd0) dec.reg_write = 1'b0;
   end

   assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) ||
                     (opcode == OP_BRANCH) || (opcode == COP_OPCODE);
   assign hazard   = HAZARD_EN && id_valid && ex_q.valid && ex_q.mem_read &&
                     (ex_q.rd != 5'd0) &&
                     ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2)));
   assign cop_in_id = id_valid && (opcode == COP_OPCODE);
   // A coprocessor op waits in ID while a branch/jump in EX may still redirect it.
   assign cop_start = (state_q == S_RUN) && cop_in_id && !hazard && !flush_i &&
                      !ex_q.branch && !ex_q.jump;
   assign timeout   = (state_q == S_COP_BUSY) && (cnt_q == CNT_LAST);

   always_comb begin
      stall_d = 1'b0;
      ex_d    = '0;
      case (state_q)
         S_RUN: begin
            stall_d = !flush_i && (hazard || cop_in_id);
            if (id_valid && !flush_i && !stall_d) ex_d = dec;
         end
         S_COP_REQ: stall_d = !flush_i;
         S_COP_BUSY: begin
            stall_d = !(cop_done || timeout);
            if (cop_done) begin
               ex_d.valid     = 1'b1;
               ex_d.reg_write = (cop_rd_q != 5'd0);
               ex_d.wb_sel    = 2'b11;
               ex_d.rd        = cop_rd_q;
            end else if (timeout) begin
               ex_d.valid   = 1'b1;
               ex_d.illegal = 1'b1;
               ex_d.rd      = cop_rd_q;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RUN;
         ex_q      <= '0;
         cnt_q     <= '0;
         cop_rd_q  <= 5'd0;
         cop_req_q <= 1'b0;
         cop_err_q <= 1'b0;
      end else begin
         ex_q <= ex_d;
         case (state_q)
            S_RUN: if (cop_start) begin
               state_q   <= S_COP_REQ;
               cop_req_q <= 1'b1;
               cop_rd_q  <= rd;
               cnt_q     <= '0;
            end
            S_COP_REQ: if (flush_i) begin
               state_q   <= S_RUN;
               cop_req_q <= 1'b0;
            end else if (cop_ready) begin
               state_q   <= S_COP_BUSY;
               cop_req_q <= 1'b0;
               cnt_q     <= '0;
            end
            S_COP_BUSY: if (cop_done) begin
               state_q <= S_RUN;
               cnt_q   <= '0;
            end else if (timeout) begin
               state_q   <= S_RUN;
               cnt_q     <= '0;
               cop_err_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            default: state_q <= S_RUN;
         endcase
      end
   end

   assign id_stall     = stall_d;
   assign cop_req      = cop_req_q;
   assign cop_err      = cop_err_q;
   assign ex_valid     = ex_q.valid;
   assign ex_alu_op    = ex_q.alu_op;
   assign ex_alu_src   = ex_q.alu_src;
   assign ex_alu_a_pc  = ex_q.alu_a_pc;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign ex_branch    = ex_q.branch;
   assign ex_jump      = ex_q.jump;
   assign ex_wb_sel    = ex_q.wb_sel;
   assign ex_rd        = ex_q.rd;
   assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios plus a randomized
// instruction stream checked against a table-driven pipeline model.
module tb_ctrl_decode_pipe;

   localparam int TMO = 8;
   localparam logic [6:0] COP_OP = 7'b0001011;

   logic        clk = 1'b0, rst = 1'b1;
   logic        id_valid = 1'b0, flush_i = 1'b0, cop_ready = 1'b0, cop_done = 1'b0;
   logic [31:0] id_instr = 32'h0;
   logic        id_stall, cop_req, cop_err, ex_valid, ex_alu_src, ex_alu_a_pc;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;
   logic [1:0]  ex_alu_op, ex_wb_sel;
   logic [4:0]  ex_rd;

   int n_vec = 0;
   int n_err = 0;

   ctrl_decode_pipe #(.COP_OPCODE(COP_OP), .COP_TIMEOUT(TMO), .HAZARD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .flush_i(flush_i),
      .cop_ready(cop_ready), .cop_done(cop_done), .id_stall(id_stall), .cop_req(cop_req),
      .cop_err(cop_err), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_alu_a_pc(ex_alu_a_pc), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Bundle layout: {valid, alu_op[2], src, a_pc, rw, mr, mw, br, j, wb[2], rd[5], illegal}
   function automatic logic [17:0] obs_bundle();
      return {ex_valid, ex_alu_op, ex_alu_src, ex_alu_a_pc, ex_reg_write, ex_mem_read,
              ex_mem_write, ex_branch, ex_jump, ex_wb_sel, ex_rd, ex_illegal};
   endfunction

   // Control table {alu_op, src, a_pc, rw, mr, mw, br, j, wb} per opcode.
   function automatic logic [17:0] exp_bundle(input logic [31:0] instr);
      logic [10:0] c;
      logic        ill;
      c   = '0;
      ill = 1'b0;
      case (instr[6:0])
         7'h33: c = 11'b10_0_0_1_0_0_0_0_00;
         7'h13: c = 11'b10_1_0_1_0_0_0_0_00;
         7'h03: c = 11'b00_1_0_1_1_0_0_0_01;
         7'h23: c = 11'b00_1_0_0_0_1_0_0_00;
         7'h63: c = 11'b01_0_0_0_0_0_1_0_00;
         7'h6F: c = 11'b00_1_1_1_0_0_0_1_10;
         7'h67: c = 11'b00_1_0_1_0_0_0_1_10;
         7'h37: c = 11'b11_1_0_1_0_0_0_0_00;
         7'h17: c = 11'b00_1_1_1_0_0_0_0_00;
         default: ill = 1'b1;
      endcase
      if (instr[11:7] == 5'd0) c[6] = 1'b0;
      return {1'b1, c, instr[11:7], ill};
   endfunction

   function automatic logic [17:0] exp_cop_done(input logic [4:0] rd);
      return {1'b1, 2'b00, 1'b0, 1'b0, (rd != 5'd0), 4'b0000, 2'b11, rd, 1'b0};
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic f,
                        input logic rdy, input logic dn);
      id_valid = v; id_instr = ins; flush_i = f; cop_ready = rdy; cop_done = dn;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] addi = 32'h00300293;
      logic [17:0] e;
      drive(1, addi, 0, 0, 0); tick();
      drive(1, 32'h0000A303, 0, 0, 0); tick();
      rst = 1'b1; #1;
      n_vec++; if (obs_bundle() !== 18'h0) begin n_err++; $display("FAIL reset_bundle: got %h want 0", obs_bundle()); end
      n_vec++; if ({cop_req, cop_err, id_stall} !== 3'b000) begin
         n_err++; $display("FAIL reset_ctrl: req/err/stall got %b want 000", {cop_req, cop_err, id_stall}); end
      tick();
      rst = 1'b0;
      drive(1, addi, 0, 0, 0); tick();
      e = exp_bundle(addi);
      n_vec++; if (obs_bundle() !== e) begin n_err++; $display("FAIL reset_addi: got %h want %h", obs_bundle(), e); end
      n_vec++; if ({ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_rd} !== {1'b1, 2'b10, 1'b1, 1'b1, 5'd5}) begin
         n_err++; $display("FAIL reset_addi_fields: got %b", {ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_rd}); end
   endtask

   task automatic test_load_use();
      logic [31:0] lw = 32'h0000A303, add_dep = 32'h002303B3, add_ind = 32'h003103B3;
      drive(1, lw, 0, 0, 0); tick();
      drive(1, add_dep, 0, 0, 0); #1;
      n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", id_stall); end
      tick();
      n_vec++; if (obs_bundle() !== 18'h0) begin n_err++; $display("FAIL lu_bubble: got %h want 0", obs_bundle()); end
      n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_one_stall: got %b want 0", id_stall); end
      tick();
      n_vec++; if (obs_bundle() !== exp_bundle(add_dep)) begin
         n_err++; $display("FAIL lu_issue: got %h want %h", obs_bundle(), exp_bundle(add_dep)); end
      drive(1, lw, 0, 0, 0); tick();
      drive(1, add_ind, 0, 0, 0); #1;
      n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_nodep_stall: got %b want 0", id_stall); end
      tick();
      n_vec++; if (obs_bundle() !== exp_bundle(add_ind)) begin
         n_err++; $display("FAIL lu_nodep_issue: got %h want %h", obs_bundle(), exp_bundle(add_ind)); end
   endtask

   task automatic test_flush();
      logic [31:0] jal = 32'h000000EF;
      drive(1, 32'h0000A303, 0, 0, 0); tick();
      drive(1, 32'h002303B3, 1, 0, 0); #1;
      n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", id_stall); end
      tick();
      n_vec++; if (obs_bundle() !== 18'h0) begin n_err++; $display("FAIL flush_bubble: got %h want 0", obs_bundle()); end
      drive(1, jal, 0, 0, 0); tick();
      n_vec++; if (obs_bundle() !== exp_bundle(jal)) begin
         n_err++; $display("FAIL flush_jal: got %h want %h", obs_bundle(), exp_bundle(jal)); end
      n_vec++; if ({ex_wb_sel, ex_jump, ex_alu_a_pc} !== 4'b1011) begin
         n_err++; $display("FAIL jal_fields: got %b want 1011", {ex_wb_sel, ex_jump, ex_alu_a_pc}); end
   endtask

   task automatic test_illegal();
      logic [31:0] bad = 32'h000001FF, add_x0 = 32'h00208033;
      drive(1, bad, 0, 0, 0); tick();
      n_vec++; if (obs_bundle() !== exp_bundle(bad)) begin
         n_err++; $display("FAIL illegal_bundle: got %h want %h", obs_bundle(), exp_bundle(bad)); end
      n_vec++; if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_write} !== 4'b1100) begin
         n_err++; $display("FAIL illegal_flags: got %b want 1100", {ex_valid, ex_illegal, ex_reg_write, ex_mem_write}); end
      drive(1, add_x0, 0, 0, 0); tick();
      n_vec++; if (ex_reg_write !== 1'b0 || ex_valid !== 1'b1) begin
         n_err++; $display("FAIL add_x0: valid/rw got %b%b want 10", ex_valid, ex_reg_write); end
      drive(0, 32'h0, 0, 0, 0); tick();
   endtask

   // k=0 detect, k=1..r in COP_REQ (ready on k=r), then BUSY cycle b=k-r.
   task automatic test_cop(input string nm, input logic [4:0] rd, input int r, input int d,
                           input bit done_given, input logic exp_err);
      logic [31:0] instr;
      int          fin_k, b, nreq;
      bit          comp;
      instr = {7'd0, 5'd2, 5'd1, 3'd0, rd, COP_OP};
      fin_k = r + (done_given ? d : TMO);
      nreq  = 0;
      drive(0, 32'h0, 0, 0, 0); tick();
      for (int k = 0; k <= fin_k; k++) begin
         b    = k - r;
         comp = (k == fin_k);
         drive(1, instr, 0, k == r, done_given && k > r && b == d);
         #1;
         n_vec++; if (id_stall !== !comp) begin
            n_err++; $display("FAIL %s_stall k=%0d: got %b want %b", nm, k, id_stall, !comp); end
         n_vec++; if (cop_req !== (k >= 1 && k <= r)) begin
            n_err++; $display("FAIL %s_req k=%0d: got %b want %b", nm, k, cop_req, (k >= 1 && k <= r)); end
         if (cop_req === 1'b1) nreq++;
         tick();
         if (!comp) begin
            n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL %s_bubble k=%0d: got %b want 0", nm, k, ex_valid); end
         end
      end
      if (done_given) begin
         n_vec++; if (obs_bundle() !== exp_cop_done(rd)) begin
            n_err++; $display("FAIL %s_result: got %h want %h", nm, obs_bundle(), exp_cop_done(rd)); end
      end else begin
         n_vec++; if ((obs_bundle() & ~18'h0003E) !== 18'h20001) begin
            n_err++; $display("FAIL %s_result: got %h want valid+illegal only", nm, obs_bundle()); end
      end
      n_vec++; if (nreq !== r) begin n_err++; $display("FAIL %s_req_cycles: got %0d want %0d", nm, nreq, r); end
      n_vec++; if (cop_err !== exp_err) begin n_err++; $display("FAIL %s_err: got %b want %b", nm, cop_err, exp_err); end
      drive(0, 32'h0, 0, 0, 0);
      repeat (3) tick();
      n_vec++; if (cop_err !== exp_err) begin n_err++; $display("FAIL %s_err_hold: got %b want %b", nm, cop_err, exp_err); end
   endtask

   task automatic test_cop_branch();
      logic [31:0] cop = {7'd0, 5'd2, 5'd1, 3'd0, 5'd9, COP_OP};
      drive(0, 32'h0, 0, 0, 0); tick();
      drive(1, 32'h00208063, 0, 0, 0); tick();
      drive(1, cop, 0, 0, 0); #1;
      n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL br_cop_hold: got %b want 1", id_stall); end
      tick();
      n_vec++; if (cop_req !== 1'b0) begin n_err++; $display("FAIL br_cop_req_early: got %b want 0", cop_req); end
      tick();
      n_vec++; if (cop_req !== 1'b1) begin n_err++; $display("FAIL br_cop_req_late: got %b want 1", cop_req); end
      drive(1, cop, 1, 0, 0); #1;
      n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL cop_flush_stall: got %b want 0", id_stall); end
      tick();
      n_vec++; if ({cop_req, ex_valid} !== 2'b00) begin
         n_err++; $display("FAIL cop_flush_abort: req/valid got %b want 00", {cop_req, ex_valid}); end
      drive(0, 32'h0, 0, 0, 0); tick();
      n_vec++; if (cop_req !== 1'b0) begin n_err++; $display("FAIL cop_flush_run: got %b want 0", cop_req); end
   endtask

   task automatic test_cop_reset();
      drive(0, 32'h0, 0, 0, 0); tick();
      drive(1, {7'd0, 5'd2, 5'd1, 3'd0, 5'd4, COP_OP}, 0, 0, 0); tick();
      n_vec++; if (cop_req !== 1'b1) begin n_err++; $display("FAIL rst_hs_req: got %b want 1", cop_req); end
      drive(0, 32'h0, 0, 0, 0);
      rst = 1'b1; #1;
      n_vec++; if ({cop_req, cop_err, id_stall, ex_valid} !== 4'b0000) begin
         n_err++; $display("FAIL rst_hs_clear: got %b want 0000", {cop_req, cop_err, id_stall, ex_valid}); end
      tick();
      rst = 1'b0;
      tick();
      n_vec++; if (cop_req !== 1'b0) begin n_err++; $display("FAIL rst_hs_run: got %b want 0", cop_req); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h5B};
      logic [17:0] m, e;
      logic [31:0] instr;
      logic        v, f, hold, exp_stall, uses2;
      logic [4:0]  mrd;
      drive(0, 32'h0, 0, 0, 0); tick();
      m = '0; hold = 1'b0; instr = '0;
      for (int i = 0; i < 300; i++) begin
         if (!hold) instr = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
         v     = hold ? 1'b1 : ($urandom_range(0, 9) != 0);
         f     = ($urandom_range(0, 7) == 0);
         mrd   = m[5:1];
         uses2 = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h23) || (instr[6:0] == 7'h63);
         exp_stall = v && !f && m[17] && m[11] && (mrd != 5'd0) &&
                     ((instr[19:15] == mrd) || (uses2 && instr[24:20] == mrd));
         drive(v, instr, f, 0, 0); #1;
         n_vec++; if (id_stall !== exp_stall) begin
            n_err++; $display("FAIL rnd_stall i=%0d: got %b want %b", i, id_stall, exp_stall); end
         tick();
         e = (v && !f && !exp_stall) ? exp_bundle(instr) : 18'h0;
         n_vec++; if (obs_bundle() !== e || cop_req !== 1'b0) begin
            n_err++; $display("FAIL rnd_bundle i=%0d: got %h req %b want %h req 0", i, obs_bundle(), cop_req, e); end
         m    = e;
         hold = exp_stall;
      end
   endtask

   initial begin
      drive(0, 32'h0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_load_use();
      test_flush();
      test_illegal();
      test_cop("cop_normal", 5'd9, 2, 5, 1'b1, 1'b0);
      test_cop("cop_done_tmo", 5'd12, 1, TMO, 1'b1, 1'b0);
      test_cop_branch();
      test_cop("cop_timeout", 5'd9, 1, 0, 1'b0, 1'b1);
      test_cop_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
